cartoon_window_core: RTL
========================

CARTOON_WINDOW_CORE -- requirements
Module: cartoon_window_core

Interface
REQ-001 SHALL have parameter IMG_W, default 640, frame width in pixels (>=3).
REQ-002 SHALL have parameter IMG_H, default 480, frame height in pixels (>=3).
REQ-003 SHALL have parameter CH, default 3, channels per pixel (1 or 3 only).
REQ-004 SHALL have parameter CW, default 8, bits per channel.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  begin a frame (honoured in IDLE only).
REQ-008 mode  in  2  0 passthrough, 1 edge map, 2 cartoon, 3 treated as 2.
REQ-009 threshold  in  8  edge threshold.
REQ-010 in_valid / in_ready  in / out  1 / 1  input pixel handshake.
REQ-011 in_pixel  in  CH*CW  raster-order input pixel, channel 0 in LSBs.
REQ-012 out_valid / out_ready  out / in  1 / 1  output pixel handshake.
REQ-013 out_pixel  out  CH*CW  processed interior pixel.
REQ-014 busy  out  1  high in RUN.
REQ-015 frame_done  out  1  one-cycle pulse at frame end.

Function
REQ-016 FSM SHALL have states IDLE, RUN, DONE: IDLE->RUN on start; RUN->DONE after the IMG_W*IMG_H-th input is accepted and the last output is handshaked; DONE->IDLE unconditionally after one cycle.
REQ-017 On IDLE->RUN, mode and threshold SHALL be captured and held for the whole frame; row/column counters SHALL clear to 0.
REQ-018 start SHALL be ignored in RUN and DONE.
REQ-019 in_ready SHALL be 0 in IDLE and DONE; in RUN, in_ready = !out_valid || out_ready.
REQ-020 A transfer SHALL occur only when valid and ready are both high in the same cycle.
REQ-021 Two line buffers of IMG_W pixels plus a 3x3 register window SHALL hold rows r-2..r for the current input at (r,c).
REQ-022 Output SHALL cover interior pixels only, (IMG_W-2)*(IMG_H-2) pixels in raster order; accepting input (r,c) with r>=2 and c>=2 SHALL produce the output for centre (r-1,c-1).
REQ-023 out_valid SHALL assert the cycle after the triggering input is accepted (latency 1).
REQ-024 While out_valid=1 and out_ready=0, out_pixel SHALL remain stable and no input SHALL be accepted.
REQ-025 Intensity I: CH=1 gives I = channel 0; CH=3 gives I = (c0 + 2*c1 + c2) >> 2, summed at CW+2 bits, truncated to CW bits.
REQ-026 gx and gy SHALL be the 3x3 Sobel responses on I, signed at CW+4 bits; mag = |gx|+|gy|, unsigned at CW+4 bits.
REQ-027 edge SHALL be mag > threshold, with threshold zero-extended; mag equal to threshold is not an edge.
REQ-028 mode 0 SHALL output the centre pixel unchanged.
REQ-029 mode 1 SHALL output all ones on edge and all zeros otherwise.
REQ-030 mode 2 SHALL output all zeros on edge; otherwise each channel SHALL be (4*centre + N + S + E + W) >> 3, computed at CW+3 bits.
REQ-031 frame_done SHALL be high exactly in the DONE cycle.
REQ-032 Column wrap SHALL occur at IMG_W-1 with the row incrementing; the window SHALL not produce output for c<2 after a wrap.

Reset
REQ-033 While rst=1, state SHALL be IDLE and in_ready, out_valid, out_pixel, busy, frame_done and all counters SHALL be 0.
REQ-034 rst mid-frame SHALL abandon the frame with no frame_done pulse; the next start SHALL begin a full new frame.
REQ-035 Line-buffer contents SHALL need no reset; no output may depend on unwritten entries.

Verification (IMG_W=IMG_H=4, CH=3, CW=8)
REQ-036 Uniform frame of 0x646464, mode 2, threshold 80 -> exactly 4 outputs, each 0x646464, then one frame_done pulse.
REQ-037 Columns 0-1 = 0x000000, columns 2-3 = 0xFFFFFF, mode 2, threshold 80 -> all 4 outputs 0x000000.
REQ-038 Same step frame, mode 1 -> all outputs 0xFFFFFF; uniform frame, mode 1 -> all outputs 0x000000.
REQ-039 Ramp frame, mode 0 -> outputs equal the input pixels at (1,1), (1,2), (2,1), (2,2), in that order.
REQ-040 out_ready held low 5 cycles with out_valid high -> in_ready=0 and out_pixel unchanged; no pixel is lost or duplicated.
REQ-041 rst asserted after 7 inputs -> all outputs 0 next cycle and no frame_done; a following start and full frame produce correct results; start pulsed during RUN is ignored.

Source files
------------

// File: rtl/cartoon_window_core.sv
// Streaming 3x3 window filter: passthrough, Sobel edge map or cartoon (smooth + black edges).
// Consumes a raster frame and emits only interior pixels, one output per window position.
module cartoon_window_core #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned CH    = 3,
  parameter int unsigned CW    = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [7:0]       threshold_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [CH*CW-1:0] in_pixel_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CH*CW-1:0] out_pixel_o,
  output logic             busy_o,
  output logic             frame_done_o
);
  localparam int unsigned PW   = CH * CW;
  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);
  localparam int unsigned SW   = CW + 4;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic            all_in_q, all_in_d;
  logic            out_valid_q, out_valid_d;
  logic [1:0]      mode_q, mode_d;
  logic [7:0]      thr_q, thr_d;
  logic            accept, trigger, last_col, last_px;

  // lb1 holds row r-1, lb2 holds row r-2; window columns run oldest (0) to newest (2).
  logic [PW-1:0]   lb1_q [IMG_W];
  logic [PW-1:0]   lb2_q [IMG_W];
  logic [PW-1:0]   win_q [3][3];

  assign in_ready_o = (state_q == StRun) && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o && !all_in_q;
  assign last_col   = (col_q == ColW'(IMG_W - 1));
  assign last_px    = last_col && (row_q == RowW'(IMG_H - 1));
  assign trigger    = accept && (col_q >= ColW'(2)) && (row_q >= RowW'(2));

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    all_in_d    = all_in_q;
    mode_d      = mode_q;
    thr_d       = thr_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
    if (trigger)                    out_valid_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StRun;
          mode_d   = mode_i;
          thr_d    = threshold_i;
          col_d    = '0;
          row_d    = '0;
          all_in_d = 1'b0;
        end
      end
      StRun: begin
        if (accept) begin
          if (last_px) all_in_d = 1'b1;
          if (last_col) begin
            col_d = '0;
            row_d = (row_q == RowW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        if (all_in_q && out_valid_q && out_ready_i) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      all_in_q    <= 1'b0;
      out_valid_q <= 1'b0;
      mode_q      <= '0;
      thr_q       <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      all_in_q    <= all_in_d;
      out_valid_q <= out_valid_d;
      mode_q      <= mode_d;
      thr_q       <= thr_d;
    end
  end

  // Storage needs no reset: outputs are gated until a full window of this frame is loaded.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb1_q[col_q] <= in_pixel_i;
      lb2_q[col_q] <= lb1_q[col_q];
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb2_q[col_q];
      win_q[1][2] <= lb1_q[col_q];
      win_q[2][2] <= in_pixel_i;
    end
  end

  function automatic logic [CW-1:0] intensity(input logic [PW-1:0] p);
    logic [CW+1:0] sum;
    sum = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      sum = sum + ((k == 1) ? ((CW+2)'(p[k*CW +: CW]) << 1) : (CW+2)'(p[k*CW +: CW]));
    end
    return (CH == 3) ? sum[CW+1:2] : p[CW-1:0];
  endfunction

  logic [CW-1:0] inten [3][3];
  logic [SW-1:0] gx_pos, gx_neg, gy_pos, gy_neg, gx, gy, ax, ay, mag;
  logic          edge_det;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        inten[i][j] = intensity(win_q[i][j]);
      end
    end
  end

  always_comb begin
    gx_pos = SW'(inten[0][2]) + (SW'(inten[1][2]) << 1) + SW'(inten[2][2]);
    gx_neg = SW'(inten[0][0]) + (SW'(inten[1][0]) << 1) + SW'(inten[2][0]);
    gy_pos = SW'(inten[2][0]) + (SW'(inten[2][1]) << 1) + SW'(inten[2][2]);
    gy_neg = SW'(inten[0][0]) + (SW'(inten[0][1]) << 1) + SW'(inten[0][2]);
    gx     = gx_pos - gx_neg;
    gy     = gy_pos - gy_neg;
    ax     = gx[SW-1] ? -gx : gx;
    ay     = gy[SW-1] ? -gy : gy;
    mag    = ax + ay;
  end

  assign edge_det = {8'b0, mag} > {{SW{1'b0}}, thr_q};

  logic [PW-1:0] pix;
  logic [CW+2:0] csum;

  always_comb begin
    pix  = '0;
    csum = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      csum = ((CW+3)'(win_q[1][1][k*CW +: CW]) << 2) + (CW+3)'(win_q[0][1][k*CW +: CW])
           + (CW+3)'(win_q[2][1][k*CW +: CW]) + (CW+3)'(win_q[1][0][k*CW +: CW])
           + (CW+3)'(win_q[1][2][k*CW +: CW]);
      case (mode_q)
        2'd0:    pix[k*CW +: CW] = win_q[1][1][k*CW +: CW];
        2'd1:    pix[k*CW +: CW] = edge_det ? '1 : '0;
        default: pix[k*CW +: CW] = edge_det ? '0 : csum[CW+2:3];
      endcase
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_pixel_o  = out_valid_q ? pix : '0;
  assign busy_o       = (state_q == StRun);
  assign frame_done_o = (state_q == StDone);

endmodule
